// File: rtl/uart_rx_param_if.sv
// Output handshake of uart_rx_param: received word qualified by valid/ready.
interface uart_rx_param_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] o_uart_data;
   logic                 o_valid;
   logic                 i_ready;

   modport master (output o_uart_data, output o_valid, input i_ready);
   modport slave  (input o_uart_data, input o_valid, output i_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x-style oversampling with 3-sample majority vote, 1-deep output.
// Optional parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic            i_clk_sys,
   input  logic            i_rst_n,
   input  logic            i_uart_rx,
   uart_rx_param_if.master rx_if,
   output logic            o_rx_done,
   output logic            o_frame_err,
   output logic            o_parity_err,
   output logic            o_overrun,
   output logic [2:0]      o_state,
   output logic            o_baud_pulse
);
   localparam int unsigned DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);
   localparam int unsigned MID    = OVERSAMPLE / 2;

   if (DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx_param: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

`ifdef UART_RX_PARITY_EN
   localparam state_t S_AFTER_DATA = S_PARITY;
`else
   localparam state_t S_AFTER_DATA = S_STOP;
`endif

   state_t                r_state, w_next_state;
   logic                  r_rx_meta, r_rx_sync, r_rx_prev;
   logic [DIV_W-1:0]      r_div_cnt;
   logic [SAMP_W-1:0]     r_samp;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic                  r_s0, r_s1;
   logic [DATA_BITS-1:0]  r_shift;
   logic [DATA_BITS-1:0]  r_data;
   logic                  r_valid, r_rx_done, r_frame_err, r_overrun, r_baud_pulse;
   logic                  w_start_edge, w_tick, w_decide, w_bit, w_last_data, w_last_stop;
   logic                  w_par_ok, w_frame_err, w_complete, w_load, w_overrun;

   // 2-FF synchroniser plus edge history; idles high
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= i_uart_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_start_edge = (r_state == S_IDLE) && r_rx_prev && !r_rx_sync;
   assign w_tick       = (r_div_cnt == DIV_W'(DIV - 1));
   assign w_decide     = w_tick && (r_samp == SAMP_W'(MID + 1)) && (r_state != S_IDLE);
   assign w_bit        = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
   assign w_last_data  = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
   assign w_last_stop  = (r_bit_cnt == BIT_W'(STOP_BITS - 1));

   // Sample timing, vote window, bit counting and data shift; timebase realigns on the start edge
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt <= '0;
         r_samp    <= '0;
         r_bit_cnt <= '0;
         r_s0      <= 1'b1;
         r_s1      <= 1'b1;
         r_shift   <= '0;
      end else if (w_start_edge) begin
         r_div_cnt <= '0;
         r_samp    <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
         if (w_tick) begin
            r_samp <= (r_samp == SAMP_W'(OVERSAMPLE - 1)) ? '0 : r_samp + 1'b1;
            if (r_samp == SAMP_W'(MID - 1)) r_s0 <= r_rx_sync;
            if (r_samp == SAMP_W'(MID))     r_s1 <= r_rx_sync;
         end
         if (w_decide) begin
            r_bit_cnt <= (w_next_state != r_state) ? '0 : r_bit_cnt + 1'b1;
            if (r_state == S_DATA) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_bit, r_parity_err;

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if (w_decide && r_state == S_PARITY) r_par_bit <= w_bit;
         r_parity_err <= w_complete && !w_par_ok;
      end
   end

   assign w_par_ok     = ((^r_shift) ^ 1'(PARITY_ODD)) == r_par_bit;
   assign o_parity_err = r_parity_err;
`else
   assign w_par_ok     = 1'b1;
   assign o_parity_err = 1'b0;
`endif

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_start_edge) w_next_state = S_START;
         S_START:  if (w_decide) w_next_state = w_bit ? S_IDLE : S_DATA;
         S_DATA:   if (w_decide && w_last_data) w_next_state = S_AFTER_DATA;
         S_PARITY: if (w_decide) w_next_state = S_STOP;
         S_STOP:   if (w_decide && (!w_bit || w_last_stop)) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Frame outcome, decided on the last stop-bit vote
   always_comb begin
      w_frame_err = 1'b0;
      w_complete  = 1'b0;
      if (w_decide && r_state == S_STOP) begin
         w_frame_err = !w_bit;
         w_complete  = w_bit && w_last_stop;
      end
      w_load    = w_complete && w_par_ok && (!r_valid || rx_if.i_ready);
      w_overrun = w_complete && w_par_ok && r_valid && !rx_if.i_ready;
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_rx_done    <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_baud_pulse <= 1'b0;
      end else begin
         r_rx_done    <= w_load;
         r_frame_err  <= w_frame_err;
         r_overrun    <= w_overrun;
         r_baud_pulse <= w_decide;
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && rx_if.i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_if.o_uart_data = r_data;
   assign rx_if.o_valid     = r_valid;
   assign o_rx_done         = r_rx_done;
   assign o_frame_err       = r_frame_err;
   assign o_overrun         = r_overrun;
   assign o_state           = r_state;
   assign o_baud_pulse      = r_baud_pulse;
endmodule
